// File: rtl/dft16_stage_ctrl.sv
// Frame sequencer for the 16-point to 8-point DFT butterfly stage.
// Loads 32 serial samples (16 fa, then 16 fb) into a bank. Waits for the
// combinational stage to settle, strobes the external capture register,
// then drains 32 result indices with a valid/ready handshake.
module dft16_stage_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned NTW_SET    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [19:0]                cfg_trun,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8:0]                 in_data,
  output logic [143:0]               fa_bus,
  output logic [143:0]               fb_bus,
  output logic [19:0]                trun,
  output logic [$clog2(NTW_SET)-1:0] tw_set,
  output logic                       cap_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_sel,
  output logic                       out_last,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int unsigned TW_W = $clog2(NTW_SET);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_cnt;
  logic [3:0]          r_settle;
  logic [31:0][8:0]    r_bank;
  logic [19:0]         r_trun;
  logic [TW_W-1:0]     r_tw_set;
  logic                r_frame_done;

  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_cnt_last;
  logic                w_settle_last;

  assign w_in_hs       = in_valid  && (r_state == S_LOAD);
  assign w_out_hs      = out_ready && (r_state == S_DRAIN);
  assign w_cnt_last    = (r_cnt == 5'd31);
  assign w_settle_last = (r_settle == 4'(SETTLE_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived handshake/strobe outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    cap_en      = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_sel     = '0;
    busy        = 1'b1;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_in_hs && w_cnt_last) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_settle_last) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cap_en      = 1'b1;
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_sel   = r_cnt;
        out_last  = w_cnt_last;
        if (w_out_hs && w_cnt_last) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // Slot/result counter, settle timer, sample bank, trun and twiddle-set registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_settle     <= '0;
      r_bank       <= '0;
      r_trun       <= '0;
      r_tw_set     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // Settle timer only runs in SETTLE and is cleared everywhere else
      if (r_state == S_SETTLE) begin
        r_settle <= r_settle + 4'd1;
      end else begin
        r_settle <= '0;
      end

      if (w_in_hs) begin
        r_bank[r_cnt] <= in_data;
        if (r_cnt == 5'd0) begin
          r_trun <= cfg_trun;
        end
        r_cnt <= w_cnt_last ? 5'd0 : r_cnt + 5'd1;
      end

      if (w_out_hs) begin
        r_cnt <= w_cnt_last ? 5'd0 : r_cnt + 5'd1;
        if (w_cnt_last) begin
          // NTW_SET is a power of two, so natural overflow gives the modulo wrap
          r_tw_set     <= r_tw_set + 1'b1;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  assign fa_bus     = r_bank[15:0];
  assign fb_bus     = r_bank[31:16];
  assign trun       = r_trun;
  assign tw_set     = r_tw_set;
  assign frame_done = r_frame_done;

endmodule
